alu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the ALU. It accepts 9-bit instructions over a valid/ready handshake and decodes them into ALU opcode/function, register-file addresses and write enables, and data-memory requests.
- It owns the architectural FLAG and OVERFLOW status registers. It captures the ALU's flag/overflow outputs into them and feeds them back as the ALU's carry/shift-in inputs.
- Sits between instruction fetch and the combinational ALU/register file in the datapath.

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer: accepts instructions over valid/ready, drives the
// ALU, register file and data memory, and owns the FLAG/OVERFLOW status registers.
module alu_sequencer #(
    parameter int IW          = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [IW-1:0] INST,
    input  logic          INST_VALID,
    output logic          INST_READY,
    output logic [2:0]    ALU_OP,
    output logic [2:0]    ALU_FUNC,
    output logic          ALU_FLAG_IN,
    output logic          ALU_OVF_IN,
    input  logic          ALU_FLAG_OUT,
    input  logic          ALU_OVF_OUT,
    output logic [2:0]    RF_RA,
    output logic [2:0]    RF_RB,
    output logic          RF_WE,
    output logic [2:0]    RF_WADDR,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    input  logic          MEM_ACK,
    output logic          MEM_ERR,
    output logic          HALTED
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MEM  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_CEQ = 3'd4;
    localparam logic [2:0] OP_CLT = 3'd5;
    localparam logic [2:0] OP_SEI = 3'd6;

    localparam logic [2:0] FN_CLRS = 3'd6;
    localparam logic [2:0] FN_HALT = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          flag_q, flag_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rf_we;

    logic [2:0] op, ra, fn;
    assign op = inst_q[8:6];
    assign ra = inst_q[5:3];
    assign fn = inst_q[2:0];

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        flag_d  = flag_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rf_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (INST_VALID) begin
                    inst_d  = INST;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op)
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    OP_ADD, OP_SUB: begin
                        rf_we = 1'b1;
                        ovf_d = ALU_OVF_OUT;
                    end
                    OP_SEI: rf_we = 1'b1;
                    OP_CEQ, OP_CLT: flag_d = ALU_FLAG_OUT;
                    default: begin
                        if (fn == FN_HALT) begin
                            state_d = S_HALT;
                        end else if (fn == FN_CLRS) begin
                            flag_d = 1'b0;
                            ovf_d  = 1'b0;
                        end else begin
                            rf_we = 1'b1;
                            ovf_d = ALU_OVF_OUT;
                        end
                    end
                endcase
            end
            S_MEM: begin
                // ACK wins over a timeout landing in the same cycle
                if (MEM_ACK) begin
                    state_d = (op == OP_LW) ? S_WB : S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status feedback is always the registered value, never bypassed
    assign ALU_FLAG_IN = flag_q;
    assign ALU_OVF_IN  = ovf_q;
    assign INST_READY  = (state_q == S_IDLE);
    assign ALU_OP      = op;
    assign ALU_FUNC    = fn;
    assign RF_RA       = ra;
    assign RF_RB       = fn;
    assign RF_WE       = rf_we;
    assign RF_WADDR    = ra;
    assign MEM_REQ     = (state_q == S_MEM);
    assign MEM_WE      = (state_q == S_MEM) && (op == OP_SW);
    assign MEM_ERR     = err_q;
    assign HALTED      = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; expected values are hand-computed per step.
module tb_alu_sequencer;

    logic       CLK;
    logic       RESET_N;
    logic [8:0] INST;
    logic       INST_VALID;
    logic       INST_READY;
    logic [2:0] ALU_OP;
    logic [2:0] ALU_FUNC;
    logic       ALU_FLAG_IN;
    logic       ALU_OVF_IN;
    logic       ALU_FLAG_OUT;
    logic       ALU_OVF_OUT;
    logic [2:0] RF_RA;
    logic [2:0] RF_RB;
    logic       RF_WE;
    logic [2:0] RF_WADDR;
    logic       MEM_REQ;
    logic       MEM_WE;
    logic       MEM_ACK;
    logic       MEM_ERR;
    logic       HALTED;

    int total;
    int bad;

    alu_sequencer #(.IW(9), .MEM_TIMEOUT(15)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .INST(INST), .INST_VALID(INST_VALID),
        .INST_READY(INST_READY), .ALU_OP(ALU_OP), .ALU_FUNC(ALU_FUNC),
        .ALU_FLAG_IN(ALU_FLAG_IN), .ALU_OVF_IN(ALU_OVF_IN),
        .ALU_FLAG_OUT(ALU_FLAG_OUT), .ALU_OVF_OUT(ALU_OVF_OUT),
        .RF_RA(RF_RA), .RF_RB(RF_RB), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ACK(MEM_ACK),
        .MEM_ERR(MEM_ERR), .HALTED(HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present an instruction for one accepting edge; returns in the EXEC cycle
    task automatic issue(input logic [8:0] ins);
        INST       = ins;
        INST_VALID = 1'b1;
        tick();
        INST_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        RESET_N = 1'b0; INST = '0; INST_VALID = 1'b0;
        ALU_FLAG_OUT = 1'b0; ALU_OVF_OUT = 1'b0; MEM_ACK = 1'b0;
        tick(); tick();
        chk("rst_ready", INST_READY, 1);
        chk("rst_rfwe", RF_WE, 0);
        chk("rst_memreq", MEM_REQ, 0);
        chk("rst_memerr", MEM_ERR, 0);
        chk("rst_halted", HALTED, 0);
        chk("rst_aluop", ALU_OP, 0);
        chk("rst_flag", ALU_FLAG_IN, 0);
        chk("rst_ovf", ALU_OVF_IN, 0);
        RESET_N = 1'b1;
        tick();

        // ADD ra=1 rb=2, ALU reports overflow
        ALU_OVF_OUT = 1'b1;
        chk("add_ready_n", INST_READY, 1);
        issue({3'd2, 3'd1, 3'd2});
        chk("add_ready_n1", INST_READY, 0);
        chk("add_rfwe", RF_WE, 1);
        chk("add_waddr", RF_WADDR, 1);
        chk("add_op", ALU_OP, 2);
        chk("add_ra", RF_RA, 1);
        chk("add_rb", RF_RB, 2);
        chk("add_ovf_nobypass", ALU_OVF_IN, 0);
        tick();
        ALU_OVF_OUT = 1'b0;
        chk("add_ready_n2", INST_READY, 1);
        chk("add_rfwe_off", RF_WE, 0);
        chk("add_ovf_in", ALU_OVF_IN, 1);

        // CEQ sets FLAG, then SHL_F sees it and clears OVERFLOW
        ALU_FLAG_OUT = 1'b1;
        issue({3'd4, 3'd0, 3'd0});
        chk("ceq_rfwe", RF_WE, 0);
        chk("ceq_flag_nobypass", ALU_FLAG_IN, 0);
        tick();
        ALU_FLAG_OUT = 1'b0;
        issue({3'd7, 3'd2, 3'd1});
        chk("shl_flag_in", ALU_FLAG_IN, 1);
        chk("shl_func", ALU_FUNC, 1);
        chk("shl_rfwe", RF_WE, 1);
        chk("shl_waddr", RF_WADDR, 2);
        tick();
        chk("shl_ovf_upd", ALU_OVF_IN, 0);
        chk("shl_flag_hold", ALU_FLAG_IN, 1);

        // LW ra=3, ACK in fourth MEM cycle; OVF_OUT must not reach OVERFLOW
        ALU_OVF_OUT = 1'b1;
        issue({3'd0, 3'd3, 3'd0});
        chk("lw_exec_rfwe", RF_WE, 0);
        chk("lw_exec_req", MEM_REQ, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_req", MEM_REQ, 1);
            chk("lw_we", MEM_WE, 0);
            chk("lw_rfwe_mem", RF_WE, 0);
            tick();
        end
        chk("lw_req4", MEM_REQ, 1);
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        chk("lw_wb_rfwe", RF_WE, 1);
        chk("lw_wb_waddr", RF_WADDR, 3);
        chk("lw_wb_req", MEM_REQ, 0);
        tick();
        chk("lw_done_rfwe", RF_WE, 0);
        chk("lw_done_ready", INST_READY, 1);
        chk("lw_ovf_kept", ALU_OVF_IN, 0);
        ALU_OVF_OUT = 1'b0;

        // SW with ACK already high on entry to MEM
        issue({3'd1, 3'd4, 3'd5});
        MEM_ACK = 1'b1;
        tick();
        chk("sw_req", MEM_REQ, 1);
        chk("sw_we", MEM_WE, 1);
        chk("sw_rfwe", RF_WE, 0);
        tick();
        MEM_ACK = 1'b0;
        chk("sw_done_req", MEM_REQ, 0);
        chk("sw_done_rfwe", RF_WE, 0);
        chk("sw_done_ready", INST_READY, 1);

        // SW with no ACK: timeout after 15 request cycles
        issue({3'd1, 3'd0, 3'd0});
        tick();
        n = 0;
        while (MEM_REQ === 1'b1 && n < 40) begin
            n++;
            chk("to_rfwe", RF_WE, 0);
            tick();
        end
        chk("to_cycles", n, 15);
        chk("to_err", MEM_ERR, 1);
        chk("to_ready", INST_READY, 1);
        chk("to_rfwe_after", RF_WE, 0);

        // ADD with overflow: MEM_ERR stays sticky, OVERFLOW set for CLRS test
        ALU_OVF_OUT = 1'b1;
        issue({3'd2, 3'd5, 3'd6});
        chk("sticky_err_exec", MEM_ERR, 1);
        tick();
        ALU_OVF_OUT = 1'b0;
        chk("sticky_err_idle", MEM_ERR, 1);
        chk("pre_clrs_flag", ALU_FLAG_IN, 1);
        chk("pre_clrs_ovf", ALU_OVF_IN, 1);

        // CLRS
        issue({3'd7, 3'd0, 3'd6});
        chk("clrs_exec_rfwe", RF_WE, 0);
        chk("clrs_exec_flag", ALU_FLAG_IN, 1);
        tick();
        chk("clrs_flag", ALU_FLAG_IN, 0);
        chk("clrs_ovf", ALU_OVF_IN, 0);

        // FLAG=1 then HALT; HALT must hold status and ignore INST_VALID
        ALU_FLAG_OUT = 1'b1;
        issue({3'd5, 3'd1, 3'd1});
        tick();
        ALU_FLAG_OUT = 1'b0;
        ALU_OVF_OUT  = 1'b1;
        issue({3'd7, 3'd0, 3'd7});
        chk("halt_exec_halted", HALTED, 0);
        INST       = {3'd2, 3'd1, 3'd1};
        INST_VALID = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", HALTED, 1);
            chk("halt_ready", INST_READY, 0);
            chk("halt_rfwe", RF_WE, 0);
            chk("halt_flag", ALU_FLAG_IN, 1);
            chk("halt_ovf", ALU_OVF_IN, 0);
            tick();
        end
        INST_VALID  = 1'b0;
        ALU_OVF_OUT = 1'b0;

        // Reset leaves HALT and clears sticky error
        RESET_N = 1'b0;
        #2;
        chk("hrst_halted", HALTED, 0);
        chk("hrst_err", MEM_ERR, 0);
        chk("hrst_ready", INST_READY, 1);
        tick();
        RESET_N = 1'b1;
        tick();

        // Set FLAG and OVERFLOW, start LW, then reset between edges mid-MEM
        ALU_FLAG_OUT = 1'b1;
        issue({3'd4, 3'd0, 3'd0});
        tick();
        ALU_FLAG_OUT = 1'b0;
        ALU_OVF_OUT  = 1'b1;
        issue({3'd3, 3'd2, 3'd0});
        tick();
        ALU_OVF_OUT = 1'b0;
        chk("mr_pre_flag", ALU_FLAG_IN, 1);
        chk("mr_pre_ovf", ALU_OVF_IN, 1);
        issue({3'd0, 3'd6, 3'd0});
        tick();
        chk("mr_req_before", MEM_REQ, 1);
        #3;
        RESET_N = 1'b0;
        #1;
        chk("mr_req", MEM_REQ, 0);
        chk("mr_flag", ALU_FLAG_IN, 0);
        chk("mr_ovf", ALU_OVF_IN, 0);
        chk("mr_rfwe", RF_WE, 0);
        tick();
        chk("mr_rfwe_held", RF_WE, 0);
        RESET_N = 1'b1;
        tick();
        chk("mr_ready", INST_READY, 1);
        chk("mr_req_after", MEM_REQ, 0);
        chk("mr_rfwe_after", RF_WE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
